// File: rtl/ucaspian_cmd_deframer.sv
// Host->device command deframer: gathers an opcode byte and its fixed-length payload
// into one wide command word, and flags unknown opcodes and stalled partial commands.
module ucaspian_cmd_deframer #(
  parameter int MAX_PAYLOAD = 4,
  parameter int TIMEOUT     = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [7:0]               in_data,
  input  logic                     in_vld,
  output logic                     in_rdy,
  output logic [7:0]               cmd_op,
  output logic [8*MAX_PAYLOAD-1:0] cmd_payload,
  output logic [2:0]               cmd_len,
  output logic                     cmd_vld,
  input  logic                     cmd_rdy,
  output logic                     err_pulse,
  output logic [1:0]               err_code,
  output logic [15:0]              cmd_count,
  output logic [7:0]               err_count
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_HOLD} state_t;

  typedef struct packed {
    logic       known;
    logic [2:0] len;
  } op_info_t;

  function automatic op_info_t decode(input logic [7:0] op);
    case (op)
      8'h00, 8'h01, 8'h10: decode = '{known: 1'b1, len: 3'd0};
      8'h02:               decode = '{known: 1'b1, len: 3'd3};
      8'h04:               decode = '{known: 1'b1, len: 3'd2};
      8'h08:               decode = '{known: 1'b1, len: 3'd4};
      default:             decode = '{known: 1'b0, len: 3'd0};
    endcase
  endfunction

  state_t                   state, state_nxt;
  op_info_t                 dec;
  logic [7:0]               asm_op;
  logic [2:0]               asm_len, idx;
  logic [8*MAX_PAYLOAD-1:0] asm_buf, buf_nxt;
  logic [TW-1:0]            to_cnt;
  logic                     accept, bad_op, timeout, deliver;
  logic                     ld_hold;
  logic [7:0]               hold_op;
  logic [8*MAX_PAYLOAD-1:0] hold_payload;
  logic [2:0]               hold_len;

  // in_rdy depends only on state, flush and reset, so a held command back-pressures the SPI side.
  assign in_rdy  = reset && !flush && (state != S_HOLD);
  assign accept  = in_vld && in_rdy;
  assign cmd_vld = (state == S_HOLD);

  // NOTE: every output of this block gets a default first so no path leaves a value held (no latch).
  always_comb begin
    state_nxt    = state;
    dec          = decode(in_data);
    bad_op       = 1'b0;
    timeout      = 1'b0;
    deliver      = 1'b0;
    ld_hold      = 1'b0;
    hold_op      = in_data;
    hold_payload = '0;
    hold_len     = 3'd0;
    buf_nxt      = asm_buf;
    for (int i = 0; i < MAX_PAYLOAD; i++)
      if (idx == 3'(i)) buf_nxt[8*i +: 8] = in_data;

    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!dec.known) begin
            bad_op = 1'b1;
          end else if (in_data == 8'h00) begin
            state_nxt = S_IDLE;
          end else if (dec.len == 3'd0) begin
            state_nxt = S_HOLD;
            ld_hold   = 1'b1;
          end else begin
            state_nxt = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (accept) begin
          if (idx == asm_len - 3'd1) begin
            state_nxt    = S_HOLD;
            ld_hold      = 1'b1;
            hold_op      = asm_op;
            hold_payload = buf_nxt;
            hold_len     = asm_len;
          end
        end else if (TIMEOUT != 0 && to_cnt == TO_LIM) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cmd_rdy) begin
          deliver   = 1'b1;
          state_nxt = S_IDLE;
        end else if (flush) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      asm_op      <= '0;
      asm_len     <= '0;
      asm_buf     <= '0;
      idx         <= '0;
      to_cnt      <= '0;
      cmd_op      <= '0;
      cmd_payload <= '0;
      cmd_len     <= '0;
      err_pulse   <= 1'b0;
      err_code    <= 2'b00;
      cmd_count   <= '0;
      err_count   <= '0;
    end else begin
      state     <= state_nxt;
      err_pulse <= bad_op || timeout;
      if (bad_op)       err_code <= 2'b01;
      else if (timeout) err_code <= 2'b10;
      if ((bad_op || timeout) && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (deliver && cmd_count != 16'hFFFF)          cmd_count <= cmd_count + 16'd1;

      if (state == S_IDLE && accept) begin
        asm_op  <= in_data;
        asm_len <= dec.len;
        asm_buf <= '0;
        idx     <= '0;
        to_cnt  <= '0;
      end else if (state == S_PAYLOAD) begin
        if (accept) begin
          asm_buf <= buf_nxt;
          idx     <= idx + 3'd1;
          to_cnt  <= '0;
        end else if (TIMEOUT != 0) begin
          to_cnt  <= to_cnt + 1'b1;
        end
      end

      if (ld_hold) begin
        cmd_op      <= hold_op;
        cmd_payload <= hold_payload;
        cmd_len     <= hold_len;
      end
    end
  end

endmodule
